// File: rtl/folded_majority_if.sv
// Handshake and result bundle between a voter-beat producer and folded_majority_unit.
interface folded_majority_if #(
  parameter int unsigned N = 59,
  parameter int unsigned W = 8
);
  localparam int unsigned CW = $clog2(N + 1);

  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          thr_mode;
  logic [CW-1:0] thr_val;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic          out_y;
  logic [CW-1:0] out_count;
  logic          busy;

  modport master (
    output in_valid, in_data, thr_mode, thr_val, flush, out_ready,
    input  in_ready, out_valid, out_y, out_count, busy
  );

  modport slave (
    input  in_valid, in_data, thr_mode, thr_val, flush, out_ready,
    output in_ready, out_valid, out_y, out_count, busy
  );
endinterface

// File: rtl/folded_majority_unit.sv
// Folded N-input threshold voter: accumulates W voter bits per beat, then holds
// the population count and threshold decision until the consumer takes it.
module folded_majority_unit #(
  parameter int unsigned N = 59,
  parameter int unsigned W = 8
) (
  input logic               clk,
  input logic               rst,
  folded_majority_if.slave  bus
);
  localparam int unsigned CW    = $clog2(N + 1);
  localparam int unsigned BEATS = (N + W - 1) / W;
  localparam int unsigned LASTW = N - (BEATS - 1) * W;
  localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] MAJ = CW'(N / 2 + 1);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [BW-1:0] beat_idx_q, beat_idx_d;
  logic [CW-1:0] acc_q, acc_d;
  logic [CW-1:0] thr_q, thr_d;
  logic [CW-1:0] out_count_q, out_count_d;
  logic          out_y_q, out_y_d;
  logic          busy_q, busy_d;

  logic          last_beat;
  logic [CW-1:0] beat_pop;
  logic [CW-1:0] sum;
  logic [CW-1:0] thr_eff;

  // Popcount of the current beat; padding bits of the final beat never count.
  always_comb begin
    last_beat = (beat_idx_q == BW'(BEATS - 1));
    beat_pop  = '0;
    for (int unsigned i = 0; i < W; i++) begin
      if (!last_beat || (i < LASTW)) begin
        beat_pop = beat_pop + CW'(bus.in_data[i]);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    beat_idx_d  = beat_idx_q;
    acc_d       = acc_q;
    thr_d       = thr_q;
    out_count_d = out_count_q;
    out_y_d     = out_y_q;

    sum     = acc_q + beat_pop;
    // Beat 0 uses the live threshold so single-beat vectors decide correctly.
    thr_eff = (beat_idx_q == '0) ? (bus.thr_mode ? bus.thr_val : MAJ) : thr_q;

    case (state_q)
      ACCUM: begin
        if (bus.flush) begin
          acc_d      = '0;
          beat_idx_d = '0;
        end else if (bus.in_valid) begin
          if (beat_idx_q == '0) begin
            thr_d = thr_eff;
          end
          if (last_beat) begin
            state_d     = HOLD;
            out_count_d = sum;
            out_y_d     = (sum >= thr_eff);
            acc_d       = '0;
            beat_idx_d  = '0;
          end else begin
            acc_d      = sum;
            beat_idx_d = beat_idx_q + BW'(1);
          end
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_d     = ACCUM;
          out_count_d = '0;
          out_y_d     = 1'b0;
        end
      end
      default: state_d = ACCUM;
    endcase

    busy_d = (beat_idx_d != '0) || (state_d == HOLD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ACCUM;
      beat_idx_q  <= '0;
      acc_q       <= '0;
      thr_q       <= '0;
      out_count_q <= '0;
      out_y_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_idx_q  <= beat_idx_d;
      acc_q       <= acc_d;
      thr_q       <= thr_d;
      out_count_q <= out_count_d;
      out_y_q     <= out_y_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = (state_q == ACCUM);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_count = out_count_q;
  assign bus.out_y     = out_y_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_folded_majority_unit.sv
// Randomized bench for folded_majority_unit (N=59, W=8) against a vector-level model.
module tb_folded_majority_unit;
  localparam int unsigned N     = 59;
  localparam int unsigned W     = 8;
  localparam int unsigned BEATS = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  folded_majority_if #(.N(N), .W(W)) bus ();

  folded_majority_unit #(.N(N), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: count the N real voters of a raw 64-bit vector image.
  function automatic int unsigned ref_count(input logic [63:0] raw);
    int unsigned c = 0;
    for (int i = 0; i < int'(N); i++) c += int'(raw[i]);
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_vector(input logic [63:0] raw, input logic mode, input logic [5:0] thrv,
                             input bit thr_change, input int gaps_max, input int hold_cyc);
    int unsigned exp_thr;
    int unsigned exp_cnt;
    logic        exp_y;
    int          g;
    exp_thr = mode ? int'(thrv) : (N / 2 + 1);
    exp_cnt = ref_count(raw);
    exp_y   = (exp_cnt >= exp_thr);
    for (int k = 0; k < int'(BEATS); k++) begin
      g = (gaps_max > 0) ? int'($urandom_range(gaps_max, 0)) : 0;
      for (int j = 0; j < g; j++) begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
        tick();
        check("gap_out_valid", 32'(bus.out_valid), 32'd0);
        check("gap_out_count", 32'(bus.out_count), 32'd0);
        check("gap_busy", 32'(bus.busy), 32'(k != 0));
      end
      bus.in_valid = 1'b1;
      bus.in_data  = raw[k*8 +: 8];
      if (k == 0) begin
        bus.thr_mode = mode;
        bus.thr_val  = thrv;
      end
      tick();
      if (k == 0 && thr_change) begin
        bus.thr_mode = 1'($urandom);
        bus.thr_val  = 6'($urandom);
      end
      if (k < int'(BEATS) - 1) begin
        check("beat_busy", 32'(bus.busy), 32'd1);
        check("beat_in_ready", 32'(bus.in_ready), 32'd1);
      end
    end
    bus.in_valid = 1'b0;
    check("res_out_valid", 32'(bus.out_valid), 32'd1);
    check("res_in_ready", 32'(bus.in_ready), 32'd0);
    check("res_out_count", 32'(bus.out_count), 32'(exp_cnt));
    check("res_out_y", 32'(bus.out_y), 32'(exp_y));
    check("res_busy", 32'(bus.busy), 32'd1);
    for (int h = 0; h < hold_cyc; h++) begin
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_data   = 8'($urandom);
      bus.flush     = 1'($urandom);
      tick();
      check("hold_out_valid", 32'(bus.out_valid), 32'd1);
      check("hold_in_ready", 32'(bus.in_ready), 32'd0);
      check("hold_out_count", 32'(bus.out_count), 32'(exp_cnt));
      check("hold_out_y", 32'(bus.out_y), 32'(exp_y));
    end
    bus.in_valid  = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("rel_out_valid", 32'(bus.out_valid), 32'd0);
    check("rel_out_count", 32'(bus.out_count), 32'd0);
    check("rel_out_y", 32'(bus.out_y), 32'd0);
    check("rel_busy", 32'(bus.busy), 32'd0);
    check("rel_in_ready", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.thr_mode  = 1'b0;
    bus.thr_val   = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_out_count", 32'(bus.out_count), 32'd0);
    check("rst_out_y", 32'(bus.out_y), 32'd0);
    rst = 1'b0;
    tick();

    // Directed vectors: zeros, 30/29 ones with padding garbage, masking, thresholds.
    send_vector(64'h0, 1'b0, 6'd0, 1'b0, 0, 0);
    send_vector(64'hF800_0000_3FFF_FFFF, 1'b0, 6'd0, 1'b0, 0, 0);
    send_vector(64'h0000_0000_1FFF_FFFF, 1'b0, 6'd0, 1'b0, 0, 0);
    send_vector(64'hFF00_0000_0000_0000, 1'b0, 6'd0, 1'b0, 0, 0);
    send_vector(64'h0, 1'b1, 6'd0, 1'b0, 0, 0);
    send_vector(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 6'd60, 1'b0, 0, 0);
    send_vector(64'h0000_0000_000F_FFFF, 1'b1, 6'd10, 1'b1, 0, 0);
    send_vector(64'h0000_0000_000F_FFFF, 1'b1, 6'd21, 1'b1, 0, 0);
    send_vector(64'h0123_4567_89AB_CDEF, 1'b0, 6'd0, 1'b0, 0, 5);

    // Reset mid-vector, then flush a partial vector.
    for (int k = 0; k < 5; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hFF;
      tick();
    end
    bus.in_valid = 1'b0;
    check("pre_rst_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1;
    check("async_rst_busy", 32'(bus.busy), 32'd0);
    check("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("async_rst_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hFF;
      tick();
    end
    bus.flush   = 1'b1;
    bus.in_data = 8'hFF;
    tick();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    check("flush_busy", 32'(bus.busy), 32'd0);
    check("flush_out_valid", 32'(bus.out_valid), 32'd0);
    send_vector(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 6'd0, 1'b0, 0, 0);

    // Randomized vectors with gaps, holds and late threshold changes.
    for (int v = 0; v < 40; v++) begin
      send_vector({$urandom, $urandom}, 1'($urandom), 6'($urandom), bit'($urandom),
                  2, int'($urandom_range(3, 0)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
